// File: rtl/arb_mux_rr_if.sv
// Handshake bundle for arb_mux_rr: N valid/ready input channels
// and one registered valid/ready output channel.
interface arb_mux_rr_if #(
  parameter int NBITS = 4,
  parameter int NCHAN = 2,
  parameter int SELW  = $clog2(NCHAN)
);
  logic [NCHAN-1:0]       in_val;
  logic [NCHAN-1:0]       in_rdy;
  logic [NCHAN*NBITS-1:0] in_msg;
  logic                   out_val;
  logic                   out_rdy;
  logic [NBITS-1:0]       out_msg;
  logic [SELW-1:0]        out_sel;

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_sel
  );

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_sel
  );
endinterface

// File: rtl/arb_mux_rr.sv
// N-channel valid/ready arbiter-mux with one registered output stage,
// round-robin or fixed-priority grant, full-throughput drain-and-load.
module arb_mux_rr #(
  parameter int NBITS = 4,
  parameter int NCHAN = 2,
  parameter int RR    = 1
) (
  input logic          clk,
  input logic          rst,
  arb_mux_rr_if.slave  bus
);
  localparam int SELW = $clog2(NCHAN);

  logic [SELW-1:0]  r_ptr;
  logic             r_val;
  logic [NBITS-1:0] r_msg;
  logic [SELW-1:0]  r_sel;

  logic             w_en;
  logic             w_xfer;
  logic [NCHAN-1:0] w_gnt;
  logic [NCHAN-1:0] w_rdy;
  logic [SELW-1:0]  w_gidx;
  logic [SELW-1:0]  w_nptr;

  assign w_en = ~r_val | bus.out_rdy;

  // Scan upward from the start point with wrap; first requester wins.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    w_gnt  = '0;
    w_gidx = '0;
    for (int k = 0; k < NCHAN; k++) begin
      idx = k + ((RR != 0) ? int'(r_ptr) : 0);
      if (idx >= NCHAN)
        idx = idx - NCHAN;
      if (!found && bus.in_val[idx]) begin
        found      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_gidx     = idx[SELW-1:0];
      end
    end
  end

  assign w_nptr = (w_gidx == SELW'(NCHAN - 1)) ? '0
                : w_gidx + 1'b1;

  assign w_rdy  = w_gnt & {NCHAN{w_en & ~rst}};
  assign w_xfer = |w_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= 1'b0;
      r_msg <= '0;
      r_sel <= '0;
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_val <= 1'b1;
      r_msg <= bus.in_msg[int'(w_gidx)*NBITS +: NBITS];
      r_sel <= w_gidx;
      if (RR != 0)
        r_ptr <= w_nptr;
    end else if (bus.out_rdy) begin
      r_val <= 1'b0;
    end
  end

  assign bus.in_rdy  = w_rdy;
  assign bus.out_val = r_val;
  assign bus.out_msg = r_msg;
  assign bus.out_sel = r_sel;
endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr across 2/3/4-channel RR and
// fixed-priority instances.
module tb_arb_mux_rr;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  arb_mux_rr_if #(.NBITS(4), .NCHAN(2)) b2 ();
  arb_mux_rr_if #(.NBITS(4), .NCHAN(3)) b3 ();
  arb_mux_rr_if #(.NBITS(4), .NCHAN(4)) b4r ();
  arb_mux_rr_if #(.NBITS(4), .NCHAN(4)) b4f ();

  arb_mux_rr #(.NBITS(4), .NCHAN(2), .RR(1)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  arb_mux_rr #(.NBITS(4), .NCHAN(3), .RR(1)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
  );
  arb_mux_rr #(.NBITS(4), .NCHAN(4), .RR(1)) u4r (
    .clk(clk), .rst(rst), .bus(b4r)
  );
  arb_mux_rr #(.NBITS(4), .NCHAN(4), .RR(0)) u4f (
    .clk(clk), .rst(rst), .bus(b4f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] e3_sel [6];
  logic [3:0] e3_msg [6];
  logic [2:0] e3_rdy [6];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    e3_sel = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    e3_msg = '{4'hA, 4'hB, 4'hC, 4'hA, 4'hB, 4'hC};
    e3_rdy = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    rst         = 1'b1;
    b2.in_val   = 2'b11;
    b2.in_msg   = {4'h6, 4'h3};
    b2.out_rdy  = 1'b0;
    b3.in_val   = '0;
    b3.in_msg   = '0;
    b3.out_rdy  = 1'b0;
    b4r.in_val  = '0;
    b4r.in_msg  = '0;
    b4r.out_rdy = 1'b0;
    b4f.in_val  = '0;
    b4f.in_msg  = '0;
    b4f.out_rdy = 1'b0;

    // reset with requests pending
    #2 chk("t1_rst_rdy0", b2.in_rdy, 32'h0);
    tick;
    chk("t1_rst_rdy1", b2.in_rdy, 32'h0);
    chk("t1_rst_val1", b2.out_val, 32'h0);
    tick;
    chk("t1_rst_rdy2", b2.in_rdy, 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_val", b2.out_val, 32'h0);
    chk("t1_msg", b2.out_msg, 32'h0);
    chk("t1_sel", b2.out_sel, 32'h0);
    chk("t1_rdy", b2.in_rdy, 32'h1);
    tick;
    chk("t1_ld_val", b2.out_val, 32'h1);
    chk("t1_ld_msg", b2.out_msg, 32'h3);
    chk("t1_ld_sel", b2.out_sel, 32'h0);
    chk("t1_hold_rdy", b2.in_rdy, 32'h0);

    // back-pressure then drain-and-load
    b2.out_rdy = 1'b1;
    b2.in_val  = 2'b10;
    b2.in_msg  = {4'h5, 4'h9};
    #1 chk("t3_rdy", b2.in_rdy, 32'h2);
    tick;
    chk("t3_val", b2.out_val, 32'h1);
    chk("t3_msg", b2.out_msg, 32'h5);
    chk("t3_sel", b2.out_sel, 32'h1);
    b2.out_rdy = 1'b0;
    b2.in_val  = 2'b01;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_bp_rdy", b2.in_rdy, 32'h0);
      chk("t3_bp_val", b2.out_val, 32'h1);
      chk("t3_bp_msg", b2.out_msg, 32'h5);
      chk("t3_bp_sel", b2.out_sel, 32'h1);
      tick;
    end
    b2.out_rdy = 1'b1;
    #1 chk("t3_dl_rdy", b2.in_rdy, 32'h1);
    tick;
    chk("t3_dl_val", b2.out_val, 32'h1);
    chk("t3_dl_msg", b2.out_msg, 32'h9);
    chk("t3_dl_sel", b2.out_sel, 32'h0);
    b2.in_val = 2'b00;
    tick;
    chk("t3_drain_val", b2.out_val, 32'h0);

    // round-robin fairness, 3 channels
    b3.out_rdy = 1'b1;
    b3.in_msg  = {4'hC, 4'hB, 4'hA};
    b3.in_val  = 3'b111;
    #1 chk("t2_rdy0", b3.in_rdy, 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t2_val", b3.out_val, 32'h1);
      chk("t2_sel", b3.out_sel, 32'(e3_sel[k]));
      chk("t2_msg", b3.out_msg, 32'(e3_msg[k]));
      chk("t2_rdy", b3.in_rdy, 32'(e3_rdy[k]));
    end
    b3.in_val = '0;

    // fixed priority starvation
    b4f.out_rdy = 1'b1;
    b4f.in_msg  = {4'h4, 4'h3, 4'h2, 4'h1};
    b4f.in_val  = 4'b1110;
    #1 chk("t4_rdy0", b4f.in_rdy, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_sel", b4f.out_sel, 32'h1);
      chk("t4_msg", b4f.out_msg, 32'h2);
      chk("t4_rdy", b4f.in_rdy, 32'h2);
    end
    b4f.in_val = 4'b1100;
    #1 chk("t4_rel_rdy", b4f.in_rdy, 32'h4);
    tick;
    chk("t4_rel_sel", b4f.out_sel, 32'h2);
    chk("t4_rel_msg", b4f.out_msg, 32'h3);
    b4f.in_val = '0;

    // round-robin wrap from ptr=3
    b4r.out_rdy = 1'b1;
    b4r.in_msg  = {4'hD, 4'hC, 4'hB, 4'hA};
    b4r.in_val  = 4'b0100;
    #1 chk("t5_rdy0", b4r.in_rdy, 32'h4);
    tick;
    chk("t5_sel0", b4r.out_sel, 32'h2);
    chk("t5_msg0", b4r.out_msg, 32'hC);
    b4r.in_val = 4'b0011;
    #1 chk("t5_wrap_rdy", b4r.in_rdy, 32'h1);
    tick;
    chk("t5_wrap_sel", b4r.out_sel, 32'h0);
    chk("t5_wrap_msg", b4r.out_msg, 32'hA);
    chk("t5_rdy2", b4r.in_rdy, 32'h2);
    tick;
    chk("t5_sel2", b4r.out_sel, 32'h1);
    chk("t5_msg2", b4r.out_msg, 32'hB);
    b4r.in_val = '0;
    tick;
    chk("t5_drain_val", b4r.out_val, 32'h0);

    // reset while a message is held
    b2.in_val = 2'b01;
    tick;
    b2.in_val  = 2'b00;
    b2.out_rdy = 1'b0;
    tick;
    chk("t6_held_val", b2.out_val, 32'h1);
    chk("t6_held_msg", b2.out_msg, 32'h9);
    rst        = 1'b1;
    b2.in_val  = 2'b11;
    b2.out_rdy = 1'b1;
    #1 chk("t6_rst_rdy", b2.in_rdy, 32'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("t6_val", b2.out_val, 32'h0);
    chk("t6_msg", b2.out_msg, 32'h0);
    chk("t6_ptr_rdy", b2.in_rdy, 32'h1);
    tick;
    chk("t6_res_val", b2.out_val, 32'h1);
    chk("t6_res_msg", b2.out_msg, 32'h9);
    chk("t6_res_sel", b2.out_sel, 32'h0);
    chk("t6_res_rdy", b2.in_rdy, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_mux_rr.md
Name: arb_mux_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes. Successor to the fixed 2:1 datapath muxes.
- Arbitrates among requesting input channels (round-robin or fixed priority) and registers the selected message into a single output pipeline stage.
- Used where several producers (e.g. memory request sources, writeback sources) share one downstream consumer. Supports back-pressure.

Parameters:
- NBITS, 4, width of each message in bits (1..32)
- NCHAN, 2, number of input channels (2..16)
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority with lowest index winning
- SELW, $clog2(NCHAN), width of out_sel; derived, not overridden

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_val  input  NCHAN  per-channel valid; bit i belongs to channel i
- in_rdy  output  NCHAN  per-channel ready; at most one bit high per cycle
- in_msg  input  NCHAN*NBITS  flattened messages; channel i occupies bits [i*NBITS +: NBITS]
- out_val  output  1  output register holds a valid message
- out_rdy  input  1  consumer accepts the message
- out_msg  output  NBITS  registered selected message
- out_sel  output  SELW  index of the channel that supplied out_msg

Behaviour:

Reset:
- rst is sampled on the clock edge. When high: out_val=0, out_msg=0, out_sel=0, priority pointer=0.
- in_rdy is all-zero during any cycle in which rst is high.
- Reset mid-transfer drops the held message. No in_rdy is asserted in that cycle, so nothing is accepted.

Stage enable:
- en = ~out_val | out_rdy, i.e. the output register is empty or is being drained this cycle.

Arbitration (combinational, same cycle):
- Among channels with in_val=1, select one grant.
- RR=1: search starts at the priority pointer ptr and proceeds upward with wrap-around, so channel ptr has highest priority and channel ptr-1 (mod NCHAN) has lowest.
- RR=0: lowest requesting index wins; ptr is ignored.
- in_rdy[i] = grant[i] & en & ~rst. Grant is one-hot or zero.

Transfer:
- Input transfer on channel i occurs when in_val[i] & in_rdy[i].
- On the next edge: out_msg <= in_msg[channel i], out_sel <= i, out_val <= 1.
- Latency is 1 cycle from input handshake to out_val.

Drain:
- Output transfer occurs when out_val & out_rdy.
- If there is no simultaneous input transfer, out_val <= 0 on the next edge. out_msg and out_sel hold their values (don't-care).
- Simultaneous drain and load in the same cycle is required. Full throughput is one message per cycle with no bubble.

Back-pressure:
- out_val=1 and out_rdy=0 gives en=0. All in_rdy=0, and out_msg and out_sel stay stable until accepted.
- out_val must not drop without a handshake.

Pointer update (RR=1 only):
- On an input transfer from channel g, ptr <= (g+1) mod NCHAN. The wrap must be correct for non-power-of-2 NCHAN (e.g. 3 -> 0).
- With no transfer, ptr holds.

Inputs:
- No input requests gives no grant and no state change except drain.
- in_msg on non-granted channels is ignored. X on those channels must not propagate.

Test Plan:
1. Reset, then idle. NCHAN=2, NBITS=4, rst=1 for 2 cycles with all in_val=1 -> in_rdy=00 throughout reset. After release: out_val=0, out_msg=0, out_sel=0, and the first grant goes to channel 0.
2. Round-robin fairness. NCHAN=3, RR=1, out_rdy=1, all in_val held at 1, in_msg = {0xC, 0xB, 0xA} for ch2..ch0 -> out_sel sequence 0,1,2,0,1,2 on consecutive cycles, out_msg sequence A,B,C,A,B,C, out_val continuously 1 after the first cycle.
3. Back-pressure. Channel 1 sends 0x5 and out_rdy=0 for 3 cycles -> out_val=1, out_msg=0x5, out_sel=1 held, in_rdy=00. Then out_rdy=1 with channel 0 valid 0x9 -> drain and load in the same cycle, next out_msg=0x9, out_sel=0.
4. Fixed priority. RR=0, NCHAN=4, in_val=1110 continuously, out_rdy=1 -> channel 1 wins every cycle and channels 2 and 3 are starved; release channel 1 -> channel 2 wins.
5. Sparse and simultaneous requests. RR=1, NCHAN=4, ptr=3 after a channel-2 grant, then in_val=0011 -> channel 0 granted (wrap), ptr becomes 1. Next in_val=0011 -> channel 1 granted.
6. Reset mid-stream. Message held with out_rdy=0, assert rst for one cycle -> out_val=0 next cycle, message discarded, ptr=0, no in_rdy during rst. Traffic resumes normally afterwards.
